// File: rtl/coffee_dispense_ctrl_if.sv
// Signal bundle between vmcoffee (master) and the brew sequencer (slave).
// COFFEE is a one-cycle request with no ready; acceptance is GRINDER rising, rejection is FAULT.
interface coffee_dispense_ctrl_if;
  logic       COFFEE;
  logic       REFILL_WATER;
  logic       REFILL_BEANS;
  logic [4:0] WATER;
  logic       BEANS;
  logic       GRINDER;
  logic       HEATER;
  logic       PUMP;
  logic       BUSY;
  logic       DONE;
  logic       FAULT;
  logic [2:0] state_dbg;

  modport master (
    output COFFEE, REFILL_WATER, REFILL_BEANS,
    input  WATER, BEANS, GRINDER, HEATER, PUMP, BUSY, DONE, FAULT, state_dbg
  );

  modport slave (
    input  COFFEE, REFILL_WATER, REFILL_BEANS,
    output WATER, BEANS, GRINDER, HEATER, PUMP, BUSY, DONE, FAULT, state_dbg
  );
endinterface

// File: rtl/coffee_dispense_ctrl.sv
// Timed grind -> heat -> pour sequencer with water/bean bookkeeping.
// Every output is a register loaded from next-state values, so nothing is combinational from inputs.
module coffee_dispense_ctrl #(
  parameter int GRIND_CYCLES  = 4,
  parameter int HEAT_CYCLES   = 6,
  parameter int POUR_CYCLES   = 8,
  parameter int WATER_PER_CUP = 5,
  parameter int WATER_MAX     = 31,
  parameter int BEAN_MAX      = 15
) (
  input logic                  clk,
  input logic                  rst,
  coffee_dispense_ctrl_if.slave bus
);

  localparam logic [7:0] GRIND_LAST = 8'(GRIND_CYCLES - 1);
  localparam logic [7:0] HEAT_LAST  = 8'(HEAT_CYCLES - 1);
  localparam logic [7:0] POUR_LAST  = 8'(POUR_CYCLES - 1);
  localparam logic [4:0] CUP_WATER  = 5'(WATER_PER_CUP);
  localparam logic [4:0] FULL_WATER = 5'(WATER_MAX);
  localparam logic [3:0] FULL_BEANS = 4'(BEAN_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRIND = 3'd1,
    S_HEAT  = 3'd2,
    S_POUR  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [4:0] level, level_n;
  logic [3:0] beans, beans_n;
  logic       fault_n;

  logic grinder_q, heater_q, pump_q, busy_q, done_q, fault_q, beans_nz_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level;
    beans_n = beans;
    fault_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.REFILL_WATER) level_n = FULL_WATER;
        if (bus.REFILL_BEANS) beans_n = FULL_BEANS;
        // A request that arrives together with a refill is rejected; the refill still lands.
        if (bus.COFFEE) begin
          if (bus.REFILL_WATER || bus.REFILL_BEANS) begin
            fault_n = 1'b1;
          end else if (level >= CUP_WATER && beans != 4'd0) begin
            state_n = S_GRIND;
            cnt_n   = 8'd0;
            beans_n = beans - 4'd1;
          end else begin
            fault_n = 1'b1;
          end
        end
      end
      S_GRIND: begin
        fault_n = bus.COFFEE;
        if (cnt == GRIND_LAST) begin
          state_n = S_HEAT;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_HEAT: begin
        fault_n = bus.COFFEE;
        if (cnt == HEAT_LAST) begin
          state_n = S_POUR;
          cnt_n   = 8'd0;
          level_n = level - CUP_WATER;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_POUR: begin
        fault_n = bus.COFFEE;
        if (cnt == POUR_LAST) begin
          state_n = S_DONE;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_DONE: begin
        fault_n = bus.COFFEE;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      level      <= 5'd0;
      beans      <= 4'd0;
      grinder_q  <= 1'b0;
      heater_q   <= 1'b0;
      pump_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      beans_nz_q <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      level      <= level_n;
      beans      <= beans_n;
      grinder_q  <= (state_n == S_GRIND);
      heater_q   <= (state_n == S_HEAT);
      pump_q     <= (state_n == S_POUR);
      busy_q     <= (state_n != S_IDLE);
      done_q     <= (state_n == S_DONE);
      fault_q    <= fault_n;
      beans_nz_q <= (beans_n != 4'd0);
    end
  end

  assign bus.WATER     = level;
  assign bus.BEANS     = beans_nz_q;
  assign bus.GRINDER   = grinder_q;
  assign bus.HEATER    = heater_q;
  assign bus.PUMP      = pump_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.FAULT     = fault_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_coffee_dispense_ctrl.sv
// Directed bench for coffee_dispense_ctrl: schedule-based reference model checked every cycle,
// plus literal expectations for phase lengths, latency and resource levels.
module tb_coffee_dispense_ctrl;

  localparam int G   = 4;
  localparam int H   = 6;
  localparam int P   = 8;
  localparam int T   = G + H + P;
  localparam int WPC = 5;
  localparam int WMX = 31;
  localparam int BMX = 15;
  localparam int W   = 12;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  coffee_dispense_ctrl_if bus();

  coffee_dispense_ctrl #(
    .GRIND_CYCLES (G),
    .HEAT_CYCLES  (H),
    .POUR_CYCLES  (P),
    .WATER_PER_CUP(WPC),
    .WATER_MAX    (WMX),
    .BEAN_MAX     (BMX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // A brew accepted at edge s owns the cycles after edges s..s+T; everything follows from j = n - s.
  logic [W-1:0] exp_q[$];
  int  n_edge   = 0;
  int  m_start  = 0;
  bit  m_active = 1'b0;
  bit  m_valid  = 1'b0;
  int  m_level  = 0;
  int  m_beans  = 0;

  always @(posedge clk) begin
    bit f, idle, on;
    int j;
    logic [W-1:0] e;
    n_edge++;
    f = 1'b0;
    if (rst) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_level  = 0;
      m_beans  = 0;
    end else if (m_valid) begin
      idle = !m_active || (n_edge - 1 - m_start) > T;
      if (idle) begin
        if (bus.COFFEE) begin
          if (bus.REFILL_WATER || bus.REFILL_BEANS) f = 1'b1;
          else if (m_level >= WPC && m_beans >= 1) begin
            m_beans--;
            m_start  = n_edge;
            m_active = 1'b1;
          end else f = 1'b1;
        end
        if (bus.REFILL_WATER) m_level = WMX;
        if (bus.REFILL_BEANS) m_beans = BMX;
      end else begin
        if (bus.COFFEE) f = 1'b1;
        if (n_edge - m_start == G + H) m_level -= WPC;
      end
    end
    if (m_valid) begin
      j  = n_edge - m_start;
      on = m_active && j >= 0 && j <= T;
      e  = {5'(m_level), m_beans != 0,
            on && j < G, on && j >= G && j < G + H, on && j >= G + H && j < T,
            on, on && j == T, f};
      exp_q.push_back(e);
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.WATER, bus.BEANS, bus.GRINDER, bus.HEATER, bus.PUMP, bus.BUSY, bus.DONE, bus.FAULT};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle_cmp edge=%0d: got %h expected %h (WATER,BEANS,GRD,HTR,PMP,BSY,DONE,FLT)",
                 n_edge, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sets inputs, lets one rising edge pass, returns at the following falling edge.
  task automatic drive(input logic c, input logic rw, input logic rb, input logic r);
    bus.COFFEE       = c;
    bus.REFILL_WATER = rw;
    bus.REFILL_BEANS = rb;
    rst              = r;
    @(negedge clk);
  endtask

  // Called right after the accepting edge; counts edges (accept edge = 1) until DONE is seen.
  task automatic run_to_done(input int inject, output int edges, output int g, output int h,
                             output int p, output int f);
    edges = 1;
    g = int'(bus.GRINDER);
    h = int'(bus.HEATER);
    p = int'(bus.PUMP);
    f = int'(bus.FAULT);
    while (!bus.DONE && edges < 40) begin
      drive(edges == inject, 1'b0, 1'b0, 1'b0);
      edges++;
      g += int'(bus.GRINDER);
      h += int'(bus.HEATER);
      p += int'(bus.PUMP);
      f += int'(bus.FAULT);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int e, g, h, p, f;
    bus.COFFEE = 1'b0;
    bus.REFILL_WATER = 1'b0;
    bus.REFILL_BEANS = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    check("reset_outputs", int'({bus.WATER, bus.BEANS, bus.GRINDER, bus.BUSY, bus.FAULT}), 0);

    // 1: empty machine rejects a request
    drive(1, 0, 0, 0);
    check("t1_fault", int'(bus.FAULT), 1);
    check("t1_grinder", int'(bus.GRINDER), 0);
    check("t1_busy", int'(bus.BUSY), 0);
    drive(0, 0, 0, 0);
    check("t1_fault_one_cycle", int'(bus.FAULT), 0);

    // 2: full refill, one cup
    drive(0, 1, 1, 0);
    check("t2_water_full", int'(bus.WATER), 31);
    drive(1, 0, 0, 0);
    check("t2_grinder_rise", int'(bus.GRINDER), 1);
    run_to_done(0, e, g, h, p, f);
    check("t2_done_edge", e, 19);
    check("t2_grind_len", g, 4);
    check("t2_heat_len", h, 6);
    check("t2_pour_len", p, 8);
    check("t2_water_after", int'(bus.WATER), 26);
    check("t2_beans_flag", int'(bus.BEANS), 1);
    drive(0, 0, 0, 0);

    // 3: request during HEAT is rejected without disturbing the sequence
    drive(0, 1, 1, 0);
    drive(1, 0, 0, 0);
    run_to_done(6, e, g, h, p, f);
    check("t3_done_edge", e, 19);
    check("t3_heat_len", h, 6);
    check("t3_faults", f, 1);
    check("t3_water_after", int'(bus.WATER), 26);
    drive(0, 0, 0, 0);
    check("t3_single_done", int'(bus.DONE), 0);

    // 4: six back-to-back cups drain 30 units
    drive(0, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0);
      run_to_done(0, e, g, h, p, f);
      check("t4_done_edge", e, 19);
      drive(0, 0, 0, 0);
    end
    check("t4_water_left", int'(bus.WATER), 1);
    drive(1, 0, 0, 0);
    check("t4_seventh_fault", int'(bus.FAULT), 1);
    check("t4_seventh_grinder", int'(bus.GRINDER), 0);
    drive(0, 0, 0, 0);

    // 5: reset during POUR
    drive(0, 1, 1, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 0);
    check("t5_in_pour", int'(bus.PUMP), 1);
    drive(0, 0, 0, 1);
    check("t5_reset_outputs",
          int'({bus.WATER, bus.BEANS, bus.GRINDER, bus.HEATER, bus.PUMP, bus.BUSY, bus.DONE, bus.FAULT}), 0);
    drive(1, 0, 0, 0);
    check("t5_post_reset_fault", int'(bus.FAULT), 1);
    check("t5_post_reset_busy", int'(bus.BUSY), 0);
    drive(0, 0, 0, 0);

    // 6: request coinciding with a water refill
    drive(0, 0, 1, 0);
    drive(1, 1, 0, 0);
    check("t6_water", int'(bus.WATER), 31);
    check("t6_fault", int'(bus.FAULT), 1);
    check("t6_no_grind", int'(bus.GRINDER), 0);
    drive(1, 0, 0, 0);
    check("t6_grind_next", int'(bus.GRINDER), 1);
    run_to_done(0, e, g, h, p, f);
    check("t6_done_edge", e, 19);
    check("t6_water_after", int'(bus.WATER), 26);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
